// File: rtl/conv_tile_controller.sv
// conv_tile_controller: tile-loop sequencer stepping FILTERS x ROWS output rows through the datapath.
// Optional RUN-stall watchdog is compiled in when CONV_CTRL_WATCHDOG_EN is defined.
module conv_tile_controller #(
    parameter int FILTERS = 4,
    parameter int ROWS    = 8,
    parameter int TIMEOUT = 255,
    localparam int FW = (FILTERS > 1) ? $clog2(FILTERS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          row_done,
    input  logic          psum_done,
    input  logic          stride_flag,
    input  logic          out_ready,
    output logic          reset_all,
    output logic          if_read_start,
    output logic          filt_read_start,
    output logic          clear_regs,
    output logic          start_rd_gen,
    output logic [FW-1:0] filt_idx,
    output logic [RW-1:0] row_idx,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTERS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    state_t        state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [RW-1:0] row_q, row_d;
    logic          wd_expired;

`ifdef CONV_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wd_q, wd_d;

    // Counts RUN cycles; anything outside RUN (including the ISSUE cycle before entry) clears it.
    always_comb begin
        wd_d = '0;
        if (state_q == S_RUN) begin
            wd_d = wd_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Fires on the TIMEOUT-th consecutive RUN cycle; row_done in that cycle still wins.
    assign wd_expired = (state_q == S_RUN) && (wd_q == WD_LAST);
`else
    localparam bit WD_EN = 1'b0;
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            filt_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    filt_d  = '0;
                    row_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (out_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (row_done) begin
                    state_d = S_NEXT;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                if (row_q < ROW_LAST) begin
                    row_d   = row_q + RW'(1);
                    state_d = S_ISSUE;
                end else begin
                    row_d = '0;
                    // A new filter needs both scratchpad readers kicked again.
                    if (filt_q < FILT_LAST) begin
                        filt_d  = filt_q + FW'(1);
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    filt_d  = '0;
                    row_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    filt_d  = '0;
                    row_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                filt_d  = '0;
                row_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            filt_d  = '0;
            row_d   = '0;
        end
    end

    always_comb begin
        reset_all       = 1'b0;
        if_read_start   = 1'b0;
        filt_read_start = 1'b0;
        clear_regs      = 1'b0;
        start_rd_gen    = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        case (state_q)
            S_IDLE: begin
                reset_all = 1'b1;
            end
            S_LOAD: begin
                if_read_start   = 1'b1;
                filt_read_start = 1'b1;
                busy            = 1'b1;
            end
            S_ISSUE: begin
                start_rd_gen = out_ready;
                busy         = 1'b1;
            end
            S_RUN: begin
                clear_regs = psum_done | stride_flag;
                busy       = 1'b1;
            end
            S_NEXT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERR: begin
                error     = WD_EN;
                reset_all = 1'b1;
            end
            default: begin
                reset_all = 1'b1;
            end
        endcase
    end

    assign filt_idx = filt_q;
    assign row_idx  = row_q;

endmodule

// File: tb/tb_conv_tile_controller.sv
// Bench for conv_tile_controller (FILTERS=2, ROWS=3, TIMEOUT=10): directed table, hand sequences
// and randomized tiles checked against a per-cycle timeline expanded from the tile rules.
module tb_conv_tile_controller;

    localparam int FILTERS = 2;
    localparam int ROWS    = 3;
    localparam int TIMEOUT = 10;
    localparam int FW      = 1;
    localparam int RW      = 2;

    // flag order: reset_all, if_read_start, filt_read_start, clear_regs, start_rd_gen, busy, done, error
    localparam logic [7:0] F_IDLE  = 8'b1000_0000;
    localparam logic [7:0] F_LOAD  = 8'b0110_0100;
    localparam logic [7:0] F_ISSUE = 8'b0000_0100;
    localparam logic [7:0] F_GO    = 8'b0000_1100;
    localparam logic [7:0] F_RUN   = 8'b0000_0100;
    localparam logic [7:0] F_RUNC  = 8'b0001_0100;
    localparam logic [7:0] F_NEXT  = 8'b0000_0100;
    localparam logic [7:0] F_DONE  = 8'b0000_0010;
    localparam logic [7:0] F_ERR   = 8'b1000_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          row_done = 1'b0;
    logic          psum_done = 1'b0;
    logic          stride_flag = 1'b0;
    logic          out_ready = 1'b0;
    logic          reset_all, if_read_start, filt_read_start, clear_regs, start_rd_gen;
    logic [FW-1:0] filt_idx;
    logic [RW-1:0] row_idx;
    logic          busy, done, error;

    conv_tile_controller #(
        .FILTERS(FILTERS),
        .ROWS   (ROWS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .row_done       (row_done),
        .psum_done      (psum_done),
        .stride_flag    (stride_flag),
        .out_ready      (out_ready),
        .reset_all      (reset_all),
        .if_read_start  (if_read_start),
        .filt_read_start(filt_read_start),
        .clear_regs     (clear_regs),
        .start_rd_gen   (start_rd_gen),
        .filt_idx       (filt_idx),
        .row_idx        (row_idx),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic       out_ready;
        logic       row_done;
        logic       psum;
        logic       stride;
        logic [7:0] flags;
        int         fi;
        int         ri;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic s, input logic a, input logic o, input logic r,
                                input logic p, input logic t, input logic [7:0] fl,
                                input int fi, input int ri);
        vec_t v;
        v.start = s; v.abort = a; v.out_ready = o; v.row_done = r;
        v.psum = p; v.stride = t; v.flags = fl; v.fi = fi; v.ri = ri;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] flags_now();
        return {reset_all, if_read_start, filt_read_start, clear_regs,
                start_rd_gen, busy, done, error};
    endfunction

    task automatic check(input string name, input logic [7:0] exp, input int fi, input int ri);
        checks++;
        if (flags_now() !== exp || int'(filt_idx) != fi || int'(row_idx) != ri) begin
            errors++;
            $display("FAIL %s: got flags=%b idx=(%0d,%0d) exp flags=%b idx=(%0d,%0d)",
                     name, flags_now(), filt_idx, row_idx, exp, fi, ri);
        end
    endtask

    // Called 1 time unit after a rising edge: drive, settle, compare, advance one cycle.
    task automatic apply(input vec_t v, input string name);
        start = v.start; abort = v.abort; out_ready = v.out_ready;
        row_done = v.row_done; psum_done = v.psum; stride_flag = v.stride;
        #1;
        check(name, v.flags, v.fi, v.ri);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[35];
        vec_t q[$];
        int   prev_fi, prev_ri, stall, dur, n_idle;
        logic s_done, load_direct, ps, st;

        tbl[0]  = mk(0,0,0,0,0,0, F_IDLE , 0,0);
        tbl[1]  = mk(1,0,0,0,0,0, F_IDLE , 0,0);
        tbl[2]  = mk(0,0,0,0,0,0, F_LOAD , 0,0);
        tbl[3]  = mk(0,0,1,0,0,0, F_GO   , 0,0);
        tbl[4]  = mk(0,0,0,0,1,0, F_RUNC , 0,0);
        tbl[5]  = mk(1,0,0,0,0,0, F_RUN  , 0,0);
        tbl[6]  = mk(0,0,0,0,0,1, F_RUNC , 0,0);
        tbl[7]  = mk(0,0,0,1,0,0, F_RUN  , 0,0);
        tbl[8]  = mk(0,0,0,1,1,0, F_NEXT , 0,0);
        tbl[9]  = mk(0,0,0,0,0,0, F_ISSUE, 0,1);
        tbl[10] = mk(0,0,0,1,0,0, F_ISSUE, 0,1);
        tbl[11] = mk(1,0,0,0,1,0, F_ISSUE, 0,1);
        tbl[12] = mk(0,0,0,0,0,1, F_ISSUE, 0,1);
        tbl[13] = mk(0,0,0,0,0,0, F_ISSUE, 0,1);
        tbl[14] = mk(0,0,1,0,0,0, F_GO   , 0,1);
        tbl[15] = mk(0,0,0,0,0,0, F_RUN  , 0,1);
        tbl[16] = mk(0,0,0,1,0,0, F_RUN  , 0,1);
        tbl[17] = mk(0,0,0,0,0,0, F_NEXT , 0,1);
        tbl[18] = mk(0,0,1,0,0,0, F_GO   , 0,2);
        tbl[19] = mk(0,0,0,1,0,0, F_RUN  , 0,2);
        tbl[20] = mk(0,0,0,0,0,0, F_NEXT , 0,2);
        tbl[21] = mk(0,0,0,0,0,0, F_LOAD , 1,0);
        tbl[22] = mk(0,0,1,0,0,0, F_GO   , 1,0);
        tbl[23] = mk(0,0,0,1,0,0, F_RUN  , 1,0);
        tbl[24] = mk(0,0,0,0,0,0, F_NEXT , 1,0);
        tbl[25] = mk(0,0,1,0,0,0, F_GO   , 1,1);
        tbl[26] = mk(0,1,0,1,0,0, F_RUN  , 1,1);
        tbl[27] = mk(0,0,0,0,0,0, F_IDLE , 0,0);
        tbl[28] = mk(0,0,0,0,0,0, F_IDLE , 0,0);
        tbl[29] = mk(1,0,0,0,0,0, F_IDLE , 0,0);
        tbl[30] = mk(0,0,0,0,0,0, F_LOAD , 0,0);
        tbl[31] = mk(0,1,1,0,0,0, F_GO   , 0,0);
        tbl[32] = mk(0,0,0,0,0,0, F_IDLE , 0,0);
        tbl[33] = mk(1,1,0,0,0,0, F_IDLE , 0,0);
        tbl[34] = mk(0,0,0,0,0,0, F_IDLE , 0,0);

        repeat (2) @(posedge clk);
        #1;
        check("in_reset", F_IDLE, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 35; i++) begin
            apply(tbl[i], $sformatf("table_%0d", i));
            $display("table vector %0d applied", i);
        end

        // asynchronous reset landing mid-cycle while in LOAD
        apply(mk(1,0,0,0,0,0, F_IDLE, 0,0), "ar_start");
        start = 1'b0;
        #1;
        check("ar_load", F_LOAD, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_reset_immediate", F_IDLE, 0, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar_after_release", F_IDLE, 0, 0);
        $display("async reset sequence done");

        apply(mk(1,0,0,0,0,0, F_IDLE, 0,0), "wd_start");
        apply(mk(0,0,0,0,0,0, F_LOAD, 0,0), "wd_load");
        apply(mk(0,0,1,0,0,0, F_GO  , 0,0), "wd_issue");
`ifdef CONV_CTRL_WATCHDOG_EN
        for (int k = 0; k < TIMEOUT; k++) begin
            apply(mk(0,0,0,0,0,0, F_RUN, 0,0), $sformatf("wd_run_%0d", k));
        end
        apply(mk(0,0,0,0,0,0, F_ERR , 0,0), "wd_err");
        apply(mk(1,0,0,0,0,0, F_ERR , 0,0), "wd_err_start");
        apply(mk(0,0,0,0,0,0, F_LOAD, 0,0), "wd_reload");
        apply(mk(0,1,0,0,0,0, F_ISSUE, 0,0), "wd_abort");
        apply(mk(0,0,0,0,0,0, F_IDLE, 0,0), "wd_idle");
        $display("watchdog sequence done");
`else
        for (int k = 0; k < 1000; k++) begin
            apply(mk(0,0,0,0,0,0, F_RUN, 0,0), $sformatf("hold_run_%0d", k));
        end
        apply(mk(0,1,0,0,0,0, F_RUN , 0,0), "hold_abort");
        apply(mk(0,0,0,0,0,0, F_IDLE, 0,0), "hold_idle");
        $display("run hold sequence done");
`endif

        // Randomized tiles: expand each tile into its expected cycle timeline.
        prev_fi = 0;
        prev_ri = 0;
        load_direct = 1'b0;
        for (int t = 0; t < 6; t++) begin
            q.delete();
            if (!load_direct) begin
                n_idle = $urandom_range(0, 2);
                for (int k = 0; k < n_idle; k++) begin
                    q.push_back(mk(0,0,rb(),rb(),rb(),rb(), F_IDLE, prev_fi, prev_ri));
                end
                q.push_back(mk(1,0,rb(),rb(),rb(),rb(), F_IDLE, prev_fi, prev_ri));
            end
            for (int f = 0; f < FILTERS; f++) begin
                q.push_back(mk(rb(),0,rb(),rb(),rb(),rb(), F_LOAD, f, 0));
                for (int r = 0; r < ROWS; r++) begin
                    stall = $urandom_range(0, 3);
                    for (int k = 0; k < stall; k++) begin
                        q.push_back(mk(rb(),0,0,rb(),rb(),rb(), F_ISSUE, f, r));
                    end
                    q.push_back(mk(rb(),0,1,rb(),rb(),rb(), F_GO, f, r));
                    dur = $urandom_range(1, TIMEOUT);
                    for (int k = 0; k < dur; k++) begin
                        ps = rb();
                        st = rb();
                        q.push_back(mk(rb(),0,rb(), logic'(k == dur - 1), ps, st,
                                       (ps | st) ? F_RUNC : F_RUN, f, r));
                    end
                    q.push_back(mk(rb(),0,rb(),rb(),rb(),rb(), F_NEXT, f, r));
                end
            end
            s_done = (t == 5) ? 1'b0 : rb();
            q.push_back(mk(s_done,0,rb(),rb(),rb(),rb(), F_DONE, FILTERS - 1, 0));
            load_direct = s_done;
            prev_fi = FILTERS - 1;
            prev_ri = 0;
            foreach (q[i]) begin
                apply(q[i], $sformatf("rand_t%0d_c%0d", t, i));
            end
            $display("random tile %0d: %0d cycles, restart_from_done=%0b", t, q.size(), s_done);
        end
        apply(mk(0,0,0,0,0,0, F_IDLE, FILTERS - 1, 0), "rand_final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_tile_controller.md
# conv_tile_controller

Top-level sequencer for the convolution datapath, generalised from single-pass control to a parametrised tile loop over `FILTERS` filters × `ROWS` output rows. It:
- kicks the IF/filter scratchpad readers;
- issues one read-generator start per output row, gated by downstream back-pressure;
- clears partial-sum registers on datapath events;
- reports progress, completion, abort and an optional stall watchdog.

It sits between the host start/abort strobes and the datapath control inputs.

## Interface
Parameters:
- `FILTERS`, 4, filters processed per tile (≥1)
- `ROWS`, 8, output rows per filter (≥1)
- `TIMEOUT`, 255, max cycles in RUN without `row_done` (watchdog build only, ≥1)
- Derived: `FW = (FILTERS>1)?$clog2(FILTERS):1`, `RW = (ROWS>1)?$clog2(ROWS):1`, `TW = $clog2(TIMEOUT+1)`

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: begin tile. Sampled in IDLE, DONE-exit or ERR only; ignored elsewhere.
- `abort` in 1: synchronous return to IDLE.
- `row_done` in 1: datapath finished current output row (`full_done`).
- `psum_done` in 1: psum accumulation boundary.
- `stride_flag` in 1: stride counter wrap.
- `out_ready` in 1: downstream can accept a new row.
- `reset_all` out 1: datapath reset.
- `if_read_start` out 1: IF reader kick.
- `filt_read_start` out 1: filter reader kick.
- `clear_regs` out 1: clear psum registers.
- `start_rd_gen` out 1: read-generator start.
- `filt_idx` out FW: current filter.
- `row_idx` out RW: current row.
- `busy` out 1: not in IDLE/DONE/ERR.
- `done` out 1: tile complete.
- `error` out 1: watchdog fired (0 when compiled out).

## Operation
- States:
  - IDLE: `reset_all`=1.
  - LOAD: `if_read_start`=`filt_read_start`=1.
  - ISSUE: `start_rd_gen`=`out_ready`.
  - RUN: `clear_regs`=`psum_done|stride_flag`.
  - NEXT: counter update.
  - DONE: `done`=1.
  - ERR: `error`=1, `reset_all`=1.
- Transitions:
  - IDLE→LOAD on `start`.
  - LOAD→ISSUE unconditionally.
  - ISSUE→RUN when `out_ready`=1; otherwise stay (stall, no pulse).
  - RUN→NEXT on `row_done`.
  - NEXT:
    - If `row_idx`<ROWS-1: `row_idx`++ and go to ISSUE.
    - Else `row_idx`←0. If `filt_idx`<FILTERS-1: `filt_idx`++ and go to LOAD (new filter reload). Else go to DONE.
  - DONE→LOAD if `start`, else →IDLE.
  - ERR→LOAD on `start`, else stay.
- Entering LOAD from IDLE/DONE/ERR zeroes `filt_idx`, `row_idx` and the watchdog counter.
- Priority: `abort` > `start` > normal next-state.
  - `abort` in any state forces IDLE next cycle and zeroes the counters.
  - `start` while `busy` has no effect.
- Outputs are decoded combinationally from state; all not listed for a state are 0.
- `filt_idx`/`row_idx` are registered and never exceed FILTERS-1/ROWS-1.
- FILTERS=1 or ROWS=1: the index stays 0 and the wrap branch is taken every time.

## Timing
- Reset: state IDLE, counters 0, so `reset_all`=1 and all other outputs 0, `busy`=0.
- `start` at edge N → LOAD in cycle N+1 → ISSUE in N+2. With `out_ready`=1, `start_rd_gen` is high in N+2 (single cycle).
- `row_done` at edge M → NEXT in M+1 → ISSUE (or LOAD) in M+2.
- Row-to-row overhead is 2 cycles; filter-to-filter overhead is 3 cycles.
- `done` is high exactly one cycle per completed tile.
- `psum_done`/`stride_flag` outside RUN are ignored.
- `row_done` outside RUN is ignored.
- `rst` mid-tile: immediate IDLE, counters 0, no `done`.

## Configuration
- `CONV_CTRL_WATCHDOG_EN` defined:
  - A TW-bit counter increments each RUN cycle and clears on entering RUN.
  - If it reaches TIMEOUT while in RUN and `row_done`=0, the next state is ERR.
  - `row_done` in the same cycle wins.
- Undefined: no counter, ERR is unreachable, `error` is tied 0, and RUN waits indefinitely.

## Test plan
- FILTERS=2, ROWS=3, `out_ready`=1, `row_done` pulsed 4 cycles after each RUN entry:
  - Expect 2 `if_read_start` pulses, 6 `start_rd_gen` pulses and 1 `done`.
  - `filt_idx`/`row_idx` sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - Back to IDLE with `reset_all`=1.
- Back-pressure: `out_ready`=0 for 5 cycles at second ISSUE → no `start_rd_gen` during those cycles, then a single pulse on the cycle `out_ready` rises; `busy` stays 1.
- `abort` asserted in RUN at row (1,1) together with `row_done` → next state IDLE, indices 0, no `done`. A later `start` restarts at (0,0).
- In RUN, `psum_done`=1 for 1 cycle and `stride_flag`=1 for 1 cycle → two `clear_regs` pulses. A `start` pulse mid-RUN causes no state change.
- Watchdog build, TIMEOUT=10, `row_done` never asserted:
  - Expect ERR after 10 RUN cycles, with `error`=1, `busy`=0 and `reset_all`=1.
  - `start` → LOAD with `error`=0.
  - Non-watchdog build: stays in RUN for 1000 cycles.
- Async `rst` pulse mid-cycle during LOAD → outputs reset immediately, `reset_all`=1, `if_read_start`=0.
